i2c_codec_target: RTL
=====================

Name: i2c_codec_target

Overview:
- Synthesizable I2C target that emulates the SSM2603 CODEC control port: a 9-bit register file behind 7-bit device address 0x1A.
- Answers the write and read sequences issued by the codec_unit controller path, so the controller can be closed-loop tested on FPGA and in simulation without the real CODEC.
- Sits on the board-side SCL/SDA pins in place of the CODEC and exposes a write-event port plus a register peek port to local logic.

Parameters:
- DEV_ADDR, 7'h1A, 7-bit I2C address matched by the target.
- NUM_REGS, 32, number of 9-bit registers implemented (addresses 0..NUM_REGS-1).
- FILT_LEN, 3, number of consecutive equal synchronized samples required before SCL/SDA level changes are accepted.

Ports:
- clk  in  1  system clock; must run at least 16x the SCL rate.
- reset  in  1  asynchronous, active-low reset.
- scl_in  in  1  SCL pin level.
- sda_in  in  1  SDA pin level.
- sda_oe  out  1  1 = pull SDA low; 0 = release SDA (open-drain).
- wr_valid  out  1  one-cycle pulse when a register write commits.
- wr_addr  out  7  register address of the committed write.
- wr_data  out  9  data of the committed write.
- peek_addr  in  7  local read address.
- peek_data  out  9  register[peek_addr], combinational; 0 when out of range.
- busy  out  1  high from an accepted address match until STOP or address mismatch.

Behaviour:
- Reset is asynchronous, active-low, and applies to all state:
  - registers all 0; reg pointer 0; state IDLE.
  - sda_oe=0, wr_valid=0, wr_addr=0, wr_data=0, busy=0.
  - Reset mid-transfer releases SDA immediately.
- Input conditioning:
  - 2-FF synchronizer, then a FILT_LEN glitch filter on both lines.
  - Internal edges (scl_rise, scl_fall) are derived from the filtered levels.
- Bus conditions:
  - START = SDA falls while SCL high; STOP = SDA rises while SCL high.
  - START is honoured in every state, including repeated START mid-transfer; it resets the bit counter and enters ADDR.
  - STOP in any state returns to IDLE.
- Bit timing:
  - SDA is sampled on scl_rise.
  - sda_oe changes only in the clk cycle after scl_fall.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits, MSB first. Match of DEV_ADDR -> ADDR_ACK, set busy. Mismatch -> IGNORE.
  - ADDR_ACK: drive ACK for one SCL period. R/W=0 -> RX_BYTE with byte index 0. R/W=1 -> TX_BYTE with byte index 0.
  - RX_BYTE / RX_ACK:
    - Byte 0 = {reg[6:0], d8}: latch into pointer and d8, then ACK.
    - Byte 1 = d[7:0]: ACK. If pointer < NUM_REGS, commit {d8, byte} to the register and pulse wr_valid with wr_addr/wr_data in the cycle the ACK begins.
    - Byte index >= 2: NACK, nothing written.
  - TX_BYTE:
    - Shift out MSB first: even byte index = reg[pointer][7:0]; odd byte index = {7'b0, reg[pointer][8]}.
    - Out of range pointer -> 0x00.
    - Data 1 bits release SDA.
  - TX_ACK_CHK: release SDA and sample the master ACK. ACK -> next byte (index toggles; no auto-increment). NACK -> IGNORE.
  - IGNORE: SDA released; wait for START or STOP.
- Pointer persistence: the pointer holds across transactions. A read without a preceding pointer write uses the last pointer.
- Partial write (only byte 0 before STOP or repeated START): pointer updated, no commit, no wr_valid.
- A STOP with no preceding START is ignored.
- A START during ADDR_ACK or TX releases SDA within 1 clk.

Test Plan:
- Write reg 0x07 = 0x1A5: START, 0x34, 0x0F, 0xA5, STOP -> three ACKs; wr_valid single pulse with wr_addr=0x07, wr_data=0x1A5; peek_data(0x07)=0x1A5.
- Read back: START, 0x34, 0x0E, repeated START, 0x35; master ACKs byte 1, NACKs byte 2; STOP -> target sends 0xA5 then 0x01; sda_oe=0 after NACK; busy falls at STOP.
- Wrong address: START, 0x36, ... -> address NACK (SDA high at 9th SCL); no wr_valid; busy stays 0 until next START.
- Three-byte write: 0x34, 0x10, 0x55, 0x77 -> third byte NACKed; reg 0x08 = 0x055 only.
- Out-of-range pointer (reg 0x30): write acked with no commit; subsequent read returns 0x00, 0x00.
- Robustness: 1-clk glitches on SCL (shorter than FILT_LEN) ignored. Reset asserted mid read byte -> sda_oe=0 same cycle; all registers read 0 afterwards.

Source files
------------

// File: rtl/i2c_codec_target.sv
// I2C target standing in for the SSM2603 control port: 9-bit registers behind DEV_ADDR.
// Filtered SCL/SDA feed a byte-level FSM; commits are reported on wr_* and readable via peek.
module i2c_codec_target #(
   parameter logic [6:0]  DEV_ADDR = 7'h1A,
   parameter int unsigned NUM_REGS = 32,
   parameter int unsigned FILT_LEN = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       sda_oe,
   output logic       wr_valid,
   output logic [6:0] wr_addr,
   output logic [8:0] wr_data,
   input  logic [6:0] peek_addr,
   output logic [8:0] peek_data,
   output logic       busy
);
   localparam int unsigned AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam int unsigned CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) + 1 : 1;
   localparam logic [CW-1:0] FILT_MAX = CW'(FILT_LEN - 1);
   localparam logic [7:0] NREGS8 = 8'(NUM_REGS);

   typedef enum logic [2:0] {
      StIdle, StAddr, StAddrAck, StRxByte, StRxAck, StTx, StTxAckChk, StIgnore
   } state_e;

   logic [1:0]    scl_sync, sda_sync;
   logic          scl_f, sda_f, scl_prev, sda_prev;
   logic [CW-1:0] scl_cnt, sda_cnt;

   // Filtered levels idle high so a reset never looks like a bus condition.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         scl_sync <= 2'b11;
         sda_sync <= 2'b11;
         scl_f    <= 1'b1;
         sda_f    <= 1'b1;
         scl_prev <= 1'b1;
         sda_prev <= 1'b1;
         scl_cnt  <= '0;
         sda_cnt  <= '0;
      end else begin
         scl_sync <= {scl_sync[0], scl_in};
         sda_sync <= {sda_sync[0], sda_in};
         scl_prev <= scl_f;
         sda_prev <= sda_f;
         if (scl_sync[1] == scl_f) begin
            scl_cnt <= '0;
         end else if (scl_cnt == FILT_MAX) begin
            scl_f   <= scl_sync[1];
            scl_cnt <= '0;
         end else begin
            scl_cnt <= scl_cnt + 1'b1;
         end
         if (sda_sync[1] == sda_f) begin
            sda_cnt <= '0;
         end else if (sda_cnt == FILT_MAX) begin
            sda_f   <= sda_sync[1];
            sda_cnt <= '0;
         end else begin
            sda_cnt <= sda_cnt + 1'b1;
         end
      end
   end

   logic scl_rise, scl_fall, start_cond, stop_cond;
   assign scl_rise   = scl_f & ~scl_prev;
   assign scl_fall   = ~scl_f & scl_prev;
   assign start_cond = scl_f & scl_prev & sda_prev & ~sda_f;
   assign stop_cond  = scl_f & scl_prev & ~sda_prev & sda_f;

   state_e     state;
   logic [3:0] bit_cnt;
   logic [7:0] shreg;
   logic [1:0] byte_idx;
   logic [6:0] ptr;
   logic       d8;
   logic       slot;  // set once the ACK bit is on the wire, cleared at the slot's end
   logic       rw;
   logic [8:0] regs [NUM_REGS];

   logic [7:0] rx_byte;
   logic       ptr_ok;
   logic [8:0] cur_reg;
   logic [7:0] tx_even, tx_odd;

   assign rx_byte = {shreg[6:0], sda_f};
   assign ptr_ok  = {1'b0, ptr} < NREGS8;

   always_comb begin
      cur_reg = '0;
      if (ptr_ok) cur_reg = regs[ptr[AW-1:0]];
   end
   assign tx_even = cur_reg[7:0];
   assign tx_odd  = {7'b0, cur_reg[8]};

   always_comb begin
      peek_data = '0;
      if ({1'b0, peek_addr} < NREGS8) peek_data = regs[peek_addr[AW-1:0]];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= StIdle;
         bit_cnt  <= '0;
         shreg    <= '0;
         byte_idx <= '0;
         ptr      <= '0;
         d8       <= 1'b0;
         slot     <= 1'b0;
         rw       <= 1'b0;
         sda_oe   <= 1'b0;
         wr_valid <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
         busy     <= 1'b0;
         for (int i = 0; i < int'(NUM_REGS); i++) regs[i] <= '0;
      end else begin
         wr_valid <= 1'b0;
         if (start_cond) begin
            state   <= StAddr;
            bit_cnt <= '0;
            slot    <= 1'b0;
            sda_oe  <= 1'b0;
         end else if (stop_cond) begin
            state  <= StIdle;
            slot   <= 1'b0;
            sda_oe <= 1'b0;
            busy   <= 1'b0;
         end else begin
            unique case (state)
               StIdle, StIgnore: sda_oe <= 1'b0;
               StAddr: begin
                  if (scl_rise) begin
                     shreg   <= rx_byte;
                     bit_cnt <= bit_cnt + 4'd1;
                     if (bit_cnt == 4'd7) begin
                        if (rx_byte[7:1] == DEV_ADDR) begin
                           state <= StAddrAck;
                           busy  <= 1'b1;
                           rw    <= rx_byte[0];
                        end else begin
                           state <= StIgnore;
                           busy  <= 1'b0;
                        end
                     end
                  end
               end
               StAddrAck: begin
                  if (scl_fall) begin
                     if (!slot) begin
                        sda_oe <= 1'b1;
                        slot   <= 1'b1;
                     end else begin
                        slot     <= 1'b0;
                        bit_cnt  <= '0;
                        byte_idx <= '0;
                        if (rw) begin
                           shreg  <= tx_even;
                           sda_oe <= ~tx_even[7];
                           state  <= StTx;
                        end else begin
                           sda_oe <= 1'b0;
                           state  <= StRxByte;
                        end
                     end
                  end
               end
               StRxByte: begin
                  if (scl_rise) begin
                     shreg   <= rx_byte;
                     bit_cnt <= bit_cnt + 4'd1;
                     if (bit_cnt == 4'd7) begin
                        state <= StRxAck;
                        if (byte_idx == 2'd0) begin
                           ptr <= rx_byte[7:1];
                           d8  <= rx_byte[0];
                        end
                     end
                  end
               end
               StRxAck: begin
                  if (scl_fall) begin
                     if (!slot) begin
                        slot   <= 1'b1;
                        sda_oe <= ~byte_idx[1];
                        if (byte_idx == 2'd1 && ptr_ok) begin
                           regs[ptr[AW-1:0]] <= {d8, shreg};
                           wr_valid          <= 1'b1;
                           wr_addr           <= ptr;
                           wr_data           <= {d8, shreg};
                        end
                     end else begin
                        slot    <= 1'b0;
                        sda_oe  <= 1'b0;
                        bit_cnt <= '0;
                        state   <= StRxByte;
                        if (!byte_idx[1]) byte_idx <= byte_idx + 2'd1;
                     end
                  end
               end
               StTx: begin
                  if (scl_rise) begin
                     bit_cnt <= bit_cnt + 4'd1;
                  end else if (scl_fall) begin
                     if (bit_cnt == 4'd8) begin
                        sda_oe <= 1'b0;
                        slot   <= 1'b0;
                        state  <= StTxAckChk;
                     end else begin
                        shreg  <= {shreg[6:0], 1'b0};
                        sda_oe <= ~shreg[6];
                     end
                  end
               end
               StTxAckChk: begin
                  if (scl_rise) begin
                     if (sda_f) state <= StIgnore;
                     else slot <= 1'b1;
                  end else if (scl_fall && slot) begin
                     slot        <= 1'b0;
                     bit_cnt     <= '0;
                     byte_idx[0] <= ~byte_idx[0];
                     shreg       <= byte_idx[0] ? tx_even : tx_odd;
                     sda_oe      <= byte_idx[0] ? ~tx_even[7] : ~tx_odd[7];
                     state       <= StTx;
                  end
               end
            endcase
         end
      end
   end
endmodule
